interrupt_controller: RTL and testbench

Holds the interrupt flag (IF, 0xFF0F) and interrupt enable (IE, 0xFFFF) registers and schedules interrupt dispatch to the CPU. It collects single-cycle request pulses from the timer, video, serial and joypad blocks. It picks the highest-priority enabled pending source and runs a request/acknowledge handshake with the CPU core. It sits on the I/O register bus beside the timer module and feeds the CPU's interrupt entry sequencer.

---
 rtl/interrupt_controller.sv | 156 +++++++++++++++
 tb/tb_interrupt_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Holds the interrupt flag (IF @ 16'hFF0F) and interrupt enable
//   (IE @ 16'hFFFF) registers. It merges single-cycle request pulses from
//   the peripheral blocks into IF and arbitrates the enabled pending
//   sources by fixed priority (bit 0 highest). It then runs a
//   request/acknowledge handshake with the CPU interrupt entry sequencer.
//
// Ports
//   I_CLOCK, I_RESET_L        system clock, async active-low reset
//   I_ADDR, IO_DATA           I/O register bus (IO_DATA driven on read hit)
//   I_RE_L, I_WE_L            bus read / write strobes, active-low
//   I_*_INT                   request pulses setting IF bits 0..4
//   I_IME                     CPU master interrupt enable
//   I_INT_ACK                 CPU acknowledge, honoured only while O_INT_REQ
//   O_INT_REQ, O_INT_VECTOR   request and service address (0x40 + 8*idx)
//   O_WAKE                    any enabled flag pending, regardless of IME
//   O_IF_DATA, O_IE_DATA      debug views of the registers
module interrupt_controller (
  input  logic        I_CLOCK,
  input  logic        I_RESET_L,
  input  logic [15:0] I_ADDR,
  inout  logic [7:0]  IO_DATA,
  input  logic        I_RE_L,
  input  logic        I_WE_L,
  input  logic        I_VBLANK_INT,
  input  logic        I_LCDC_INT,
  input  logic        I_TIMER_INT,
  input  logic        I_SERIAL_INT,
  input  logic        I_JOYPAD_INT,
  input  logic        I_IME,
  input  logic        I_INT_ACK,
  output logic        O_INT_REQ,
  output logic [15:0] O_INT_VECTOR,
  output logic        O_WAKE,
  output logic [7:0]  O_IF_DATA,
  output logic [7:0]  O_IE_DATA
);

  localparam logic [15:0] IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IE_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  if_q, if_d;
  logic [7:0]  ie_q, ie_d;
  logic [2:0]  idx_q, idx_d;

  logic        if_hit, ie_hit;
  logic        if_we, ie_we, rd_hit;
  logic [4:0]  src_pulses;
  logic [4:0]  pending;
  logic [4:0]  ack_mask;
  logic        ack_ok;
  logic [2:0]  sel_idx;
  logic [7:0]  rd_data;

  // --------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------
  assign if_hit = (I_ADDR == IF_ADDR);
  assign ie_hit = (I_ADDR == IE_ADDR);
  assign if_we  = ~I_WE_L & if_hit;
  assign ie_we  = ~I_WE_L & ie_hit;
  assign rd_hit = ~I_RE_L & (if_hit | ie_hit);

  assign rd_data = if_hit ? {3'b111, if_q} : ie_q;
  assign IO_DATA = rd_hit ? rd_data : 'z;

  // --------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------
  assign src_pulses = {I_JOYPAD_INT, I_SERIAL_INT, I_TIMER_INT,
                       I_LCDC_INT, I_VBLANK_INT};
  assign pending    = if_q & ie_q[4:0];

  // Scan from the lowest-priority bit upward so the last match, the
  // lowest set bit, wins.
  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (pending[4 - i]) sel_idx = 3'(4 - i);
    end
  end

  // An ack is honoured only while a request is actually outstanding.
  assign ack_ok   = (state_q == REQ) & I_INT_ACK;
  assign ack_mask = ack_ok ? (5'b00001 << idx_q) : '0;

  // --------------------------------------------------------------------
  // Register next-state. A source pulse outranks both the ack clear and a
  // CPU write of zero, so the OR is applied last.
  // --------------------------------------------------------------------
  always_comb begin
    if_d = ((if_we ? IO_DATA[4:0] : if_q) & ~ack_mask) | src_pulses;
    ie_d = ie_we ? IO_DATA : ie_q;
  end

  // --------------------------------------------------------------------
  // Handshake FSM
  // --------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (I_IME && (pending != '0)) begin
          idx_d   = sel_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        // idx stays frozen here; ack wins over any abort in the same cycle.
        if (I_INT_ACK) begin
          state_d = DONE;
        end else if (!I_IME || !(|(pending & (5'b00001 << idx_q)))) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state_q <= IDLE;
      if_q    <= '0;
      ie_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if_q    <= if_d;
      ie_q    <= ie_d;
      idx_q   <= idx_d;
    end
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign O_INT_REQ    = (state_q == REQ);
  assign O_INT_VECTOR = 16'h0040 + {10'd0, idx_q, 3'b000};
  assign O_WAKE       = |pending;
  assign O_IF_DATA    = {3'b111, if_q};
  assign O_IE_DATA    = ie_q;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] addr;
  logic        re_l, we_l;
  logic [4:0]  src;
  logic        ime, ack;
  logic        drv_en;
  logic [7:0]  drv;
  wire  [7:0]  io_data;

  logic        int_req, wake;
  logic [15:0] int_vec;
  logic [7:0]  if_dbg, ie_dbg;

  assign io_data = drv_en ? drv : 8'hzz;

  interrupt_controller dut (
    .I_CLOCK      (clk),
    .I_RESET_L    (rst_n),
    .I_ADDR       (addr),
    .IO_DATA      (io_data),
    .I_RE_L       (re_l),
    .I_WE_L       (we_l),
    .I_VBLANK_INT (src[0]),
    .I_LCDC_INT   (src[1]),
    .I_TIMER_INT  (src[2]),
    .I_SERIAL_INT (src[3]),
    .I_JOYPAD_INT (src[4]),
    .I_IME        (ime),
    .I_INT_ACK    (ack),
    .O_INT_REQ    (int_req),
    .O_INT_VECTOR (int_vec),
    .O_WAKE       (wake),
    .O_IF_DATA    (if_dbg),
    .O_IE_DATA    (ie_dbg)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        req;
    logic [15:0] vec;
    logic        wake;
    logic [7:0]  ifd;
    logic [7:0]  ied;
    logic [7:0]  bus;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: register contents as plain integers, handshake as
  // two flags (request outstanding / cool-down cycle) plus chosen source.
  int m_if, m_ie, m_idx;
  bit m_req, m_done;

  function automatic void model_reset();
    m_if = 0; m_ie = 0; m_idx = 0; m_req = 0; m_done = 0;
  endfunction

  function automatic void model_step(input logic [4:0] s, input bit i_ime,
                                     input bit i_ack, input int op,
                                     input logic [15:0] a, input logic [7:0] wd);
    int pend, nif, nie, k;
    pend = m_if & m_ie & 31;
    nif  = (op == 2 && a == 16'hFF0F) ? (int'(wd) & 31) : m_if;
    if (m_req && i_ack) nif = nif & ~(1 << m_idx);
    nif  = nif | int'(s);
    nie  = (op == 2 && a == 16'hFFFF) ? int'(wd) : m_ie;
    if (m_req) begin
      if (i_ack) begin
        m_req = 0; m_done = 1;
      end else if (!i_ime || ((pend >> m_idx) & 1) == 0) begin
        m_req = 0;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (i_ime && pend != 0) begin
      k = 0;
      while (((pend >> k) & 1) == 0) k++;
      m_idx = k;
      m_req = 1;
    end
    m_if = nif;
    m_ie = nie;
  endfunction

  // One bus cycle, called just after a rising edge. op: 0 idle, 1 read, 2 write.
  task automatic cyc(input logic [4:0] s, input bit i_ime, input bit i_ack,
                     input int op, input logic [15:0] a, input logic [7:0] wd,
                     input bit rst);
    exp_t e;
    bit hit;
    rst_n = !rst;
    if (rst) model_reset();
    e.req  = m_req;
    e.vec  = 16'(64 + 8 * m_idx);
    e.wake = ((m_if & m_ie & 31) != 0);
    e.ifd  = 8'(224 | m_if);
    e.ied  = 8'(m_ie);
    hit    = (a == 16'hFF0F) || (a == 16'hFFFF);
    if (op == 1 && hit) e.bus = (a == 16'hFF0F) ? e.ifd : e.ied;
    else if (op == 2)   e.bus = wd;
    else                e.bus = 8'hzz;
    exp_q.push_back(e);
    addr   = a;
    re_l   = !(op == 1);
    we_l   = !(op == 2);
    drv_en = (op == 2);
    drv    = wd;
    src    = s;
    ime    = i_ime;
    ack    = i_ack;
    if (!rst) model_step(s, i_ime, i_ack, op, a, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit i_ime);
    for (int i = 0; i < n; i++) cyc(5'd0, i_ime, 1'b0, 0, 16'h0000, 8'h00, 1'b0);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare to the oldest
  // queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("int_req", {15'd0, int_req}, {15'd0, e.req});
      chk("int_vector", int_vec, e.vec);
      chk("wake", {15'd0, wake}, {15'd0, e.wake});
      chk("if_data", {8'd0, if_dbg}, {8'd0, e.ifd});
      chk("ie_data", {8'd0, ie_dbg}, {8'd0, e.ied});
      chk("io_data", {8'd0, io_data}, {8'd0, e.bus});
    end
  end

  bit          r_ime;
  logic [4:0]  r_src;
  logic [15:0] r_addr;
  int          r_op, r_sel;

  initial begin
    rst_n = 1'b0; addr = '0; re_l = 1'b1; we_l = 1'b1; src = '0;
    ime = 1'b0; ack = 1'b0; drv_en = 1'b0; drv = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state
    cyc(5'd0, 0, 0, 1, 16'hFF0F, 8'h00, 1);
    cyc(5'd0, 0, 0, 1, 16'hFFFF, 8'h00, 1);
    idle(1, 0);

    // Timer interrupt, single source
    cyc(5'd0, 1, 0, 2, 16'hFFFF, 8'h04, 0);
    cyc(5'b00100, 1, 0, 0, 16'h0000, 8'h00, 0);
    cyc(5'd0, 1, 0, 1, 16'hFF0F, 8'h00, 0);
    idle(2, 1);
    cyc(5'd0, 1, 1, 0, 16'h0000, 8'h00, 0);
    idle(2, 1);
    cyc(5'd0, 1, 0, 1, 16'hFF0F, 8'h00, 0);

    // Two sources at once: priority order
    cyc(5'd0, 1, 0, 2, 16'hFFFF, 8'h1F, 0);
    cyc(5'b10001, 1, 0, 0, 16'h0000, 8'h00, 0);
    idle(2, 1);
    cyc(5'd0, 1, 1, 0, 16'h0000, 8'h00, 0);
    idle(3, 1);
    cyc(5'd0, 1, 1, 0, 16'h0000, 8'h00, 0);
    idle(2, 1);
    cyc(5'd0, 1, 0, 1, 16'hFF0F, 8'h00, 0);

    // Wake without IME, then enable IME
    cyc(5'd0, 0, 0, 2, 16'hFFFF, 8'h01, 0);
    cyc(5'b00001, 0, 0, 0, 16'h0000, 8'h00, 0);
    idle(3, 0);
    idle(3, 1);
    cyc(5'd0, 1, 1, 0, 16'h0000, 8'h00, 0);
    idle(2, 1);

    // IME drop during REQ aborts without clearing
    cyc(5'd0, 1, 0, 2, 16'hFFFF, 8'h04, 0);
    cyc(5'b00100, 1, 0, 0, 16'h0000, 8'h00, 0);
    idle(2, 1);
    idle(2, 0);
    cyc(5'd0, 0, 0, 1, 16'hFF0F, 8'h00, 0);
    idle(3, 1);

    // Ack coinciding with a new pulse on the same bit
    cyc(5'b00100, 1, 1, 0, 16'h0000, 8'h00, 0);
    cyc(5'd0, 1, 0, 1, 16'hFF0F, 8'h00, 0);
    idle(3, 1);
    cyc(5'd0, 1, 1, 0, 16'h0000, 8'h00, 0);
    idle(2, 1);

    // Register writes, write vs. source precedence, reset mid-REQ
    cyc(5'd0, 0, 0, 2, 16'hFF0F, 8'hFF, 0);
    cyc(5'd0, 0, 0, 1, 16'hFF0F, 8'h00, 0);
    cyc(5'b01000, 0, 0, 2, 16'hFF0F, 8'h00, 0);
    cyc(5'd0, 0, 0, 1, 16'hFF0F, 8'h00, 0);
    cyc(5'd0, 1, 0, 2, 16'hFF0F, 8'h04, 0);
    idle(2, 1);
    cyc(5'd0, 1, 0, 1, 16'hFF0F, 8'h00, 1);
    cyc(5'd0, 1, 0, 1, 16'hFFFF, 8'h00, 1);
    idle(2, 1);

    // Randomized traffic
    r_ime = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 5; b++) r_src[b] = ($urandom % 10 == 0);
      if ($urandom % 20 == 0) r_ime = !r_ime;
      r_sel = $urandom % 5;
      r_addr = (r_sel < 2) ? 16'hFF0F : (r_sel < 4) ? 16'hFFFF : 16'($urandom);
      r_op = $urandom % 10;
      r_op = (r_op < 2) ? 1 : (r_op == 2) ? 2 : 0;
      cyc(r_src, r_ime, m_req ? ($urandom % 3 == 0) : ($urandom % 20 == 0),
          r_op, r_addr, 8'($urandom), ($urandom % 400 == 0));
    end
    idle(1, 1);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
